// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite types and the byte-lane strobe helper used by the memory slave.
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3
  } hsize_t;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } slave_state_t;

  // Strobe for a transfer of 2^size bytes starting at byte offset addr within the word.
  function automatic logic [7:0] lane_mask(input logic [2:0] size, input logic [2:0] addr);
    logic [7:0] base;
    case (size)
      3'd0:    base = 8'h01;
      3'd1:    base = 8'h03;
      3'd2:    base = 8'h0F;
      3'd3:    base = 8'hFF;
      default: base = 8'h00;
    endcase
    return base << addr;
  endfunction

endpackage

// File: rtl/ahb_lite_mem_array.sv
// Byte-enable word RAM: single synchronous write port, asynchronous read of the same word.
module ahb_lite_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [DATA_WIDTH/8-1:0]      be,
  input  logic [$clog2(MEM_DEPTH)-1:0] addr,
  input  logic [DATA_WIDTH-1:0]        wdata,
  output logic [DATA_WIDTH-1:0]        rdata
);

  logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (be[b]) begin
          mem_r[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  assign rdata = mem_r[addr];

endmodule

// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite memory slave: pipelined address/data phases, programmable wait states,
// two-cycle ERROR response and byte-lane writes.
module ahb_lite_mem_slave
  import ahb_lite_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    MEM_DEPTH   = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int                    WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int NBYTES    = DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(NBYTES);
  localparam int IDX_BITS  = $clog2(MEM_DEPTH);
  localparam int OFF_BITS  = IDX_BITS + LANE_BITS;
  localparam logic [ADDR_WIDTH:0] RANGE_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] RANGE_HI = RANGE_LO + (ADDR_WIDTH+1)'(NBYTES * MEM_DEPTH);
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  slave_state_t state_r, state_s;
  logic [3:0]            cnt_r, cnt_s;
  logic                  dp_valid_r, write_r;
  logic [2:0]            size_r;
  logic [OFF_BITS-1:0]   off_r;
  logic                  capture_s, err_s, in_range_s, size_bad_s, misaligned_s;
  logic [ADDR_WIDTH:0]   haddr_ext_s;
  logic [ADDR_WIDTH-1:0] offset_s;
  logic [6:0]            align_mask_s;
  logic                  ready_s, we_s;
  logic [NBYTES-1:0]     strobe_s;
  logic [DATA_WIDTH-1:0] rdata_s;
  logic                  unused_s;

  assign capture_s    = HSEL & HREADY & HTRANS[1];
  assign haddr_ext_s  = {1'b0, HADDR};
  assign in_range_s   = (haddr_ext_s >= RANGE_LO) && (haddr_ext_s < RANGE_HI);
  assign size_bad_s   = HSIZE > 3'(LANE_BITS);
  assign align_mask_s = (7'd1 << HSIZE) - 7'd1;
  assign misaligned_s = |(HADDR[6:0] & align_mask_s);
  assign err_s        = ~in_range_s | size_bad_s | misaligned_s;
  assign offset_s     = HADDR - BASE_ADDR;
  assign unused_s     = ^{HBURST, HPROT, HTRANS[0], offset_s};

  // State register and wait-state counter.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state logic; ERR2 doubles as a capture point just like IDLE.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE, ST_ERR2: begin
        if (capture_s) begin
          if (err_s) begin
            state_s = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_s = ST_WAIT;
            cnt_s   = WAIT_LOAD;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_s = ST_IDLE;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      ST_ERR1: state_s = ST_ERR2;
      default: state_s = ST_IDLE;
    endcase
  end

  assign ready_s   = (state_r != ST_WAIT) && (state_r != ST_ERR1);
  assign HREADYOUT = ready_s;
  assign HRESP     = (state_r == ST_ERR1) || (state_r == ST_ERR2);

  // Data-phase context; dp_valid_r marks an OKAY transfer whose data phase is in flight.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid_r <= 1'b0;
      write_r    <= 1'b0;
      size_r     <= 3'd0;
      off_r      <= '0;
    end else if (capture_s) begin
      dp_valid_r <= ~err_s;
      write_r    <= HWRITE;
      size_r     <= HSIZE;
      off_r      <= offset_s[OFF_BITS-1:0];
    end else if (ready_s) begin
      dp_valid_r <= 1'b0;
    end
  end

  assign we_s     = dp_valid_r & write_r & ready_s;
  assign strobe_s = NBYTES'(lane_mask(size_r, 3'(off_r[LANE_BITS-1:0])));
  assign HRDATA   = (dp_valid_r & ~write_r) ? rdata_s : {DATA_WIDTH{1'b0}};

  ahb_lite_mem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_mem (
    .clk  (HCLK),
    .we   (we_s),
    .be   (strobe_s),
    .addr (off_r[OFF_BITS-1:LANE_BITS]),
    .wdata(HWDATA),
    .rdata(rdata_s)
  );

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Directed bench: one zero-wait slave and one three-wait-state slave sharing the bus signals.
module tb_ahb_lite_mem_slave;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        hsel0, hsel1;
  logic [31:0] HADDR, HWDATA;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic [31:0] hrdata0, hrdata1;
  logic        hro0, hro1, hresp0, hresp1;

  bit          sel;
  logic        rdy, resp;
  logic [31:0] rdata;
  int          checks = 0;
  int          errors = 0;

  always #5 HCLK = ~HCLK;

  assign rdy   = sel ? hro1 : hro0;
  assign resp  = sel ? hresp1 : hresp0;
  assign rdata = sel ? hrdata1 : hrdata0;

  ahb_lite_mem_slave #(.WAIT_STATES(0)) dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel0), .HADDR(HADDR), .HWDATA(HWDATA),
    .HRDATA(hrdata0), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HTRANS(HTRANS), .HREADY(hro0), .HREADYOUT(hro0), .HRESP(hresp0));

  ahb_lite_mem_slave #(.WAIT_STATES(3)) dut1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel1), .HADDR(HADDR), .HWDATA(HWDATA),
    .HRDATA(hrdata1), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HTRANS(HTRANS), .HREADY(hro1), .HREADYOUT(hro1), .HRESP(hresp1));

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic bus_idle();
    hsel0 = 1'b0; hsel1 = 1'b0; HTRANS = 2'd0; HWRITE = 1'b0;
    HSIZE = 3'd2; HBURST = 3'd0; HPROT = 4'd0;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic wr, input logic [2:0] sz,
                            input logic [1:0] tr);
    hsel0 = ~sel; hsel1 = sel; HADDR = a; HWRITE = wr; HSIZE = sz; HTRANS = tr;
  endtask

  // Non-pipelined transfer; returns data/response seen in the completing cycle.
  task automatic single(input logic [31:0] a, input logic wr, input logic [2:0] sz,
                        input logic [31:0] wd, output logic [31:0] rd, output int low,
                        output logic err);
    addr_phase(a, wr, sz, 2'd2);
    tick();
    bus_idle();
    HWDATA = wd;
    low = 0;
    while (!rdy && low < 40) begin
      tick();
      low++;
    end
    if (!rdy) begin
      checks++; errors++;
      $display("FAIL timeout addr=%h: HREADYOUT never returned high", a);
    end
    rd  = rdata;
    err = resp;
    tick();
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    bus_idle();
    HADDR = 32'd0; HWDATA = 32'd0;
    #12;
    checks++; if (hro0 !== 1'b1) begin errors++; $display("FAIL reset_ready0 got=%b exp=1", hro0); end
    checks++; if (hresp0 !== 1'b0) begin errors++; $display("FAIL reset_resp0 got=%b exp=0", hresp0); end
    checks++; if (hrdata0 !== 32'd0) begin errors++; $display("FAIL reset_rdata0 got=%h exp=0", hrdata0); end
    checks++; if (hro1 !== 1'b1) begin errors++; $display("FAIL reset_ready1 got=%b exp=1", hro1); end
    checks++; if (hresp1 !== 1'b0) begin errors++; $display("FAIL reset_resp1 got=%b exp=0", hresp1); end
    @(negedge HCLK);
    HRESETn = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    addr_phase(32'h10, 1'b1, 3'd2, 2'd2);
    tick();
    HWDATA = 32'hDEAD_BEEF;
    addr_phase(32'h10, 1'b0, 3'd2, 2'd2);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL b2b_wr_ready got=%b exp=1", rdy); end
    checks++; if (resp !== 1'b0) begin errors++; $display("FAIL b2b_wr_resp got=%b exp=0", resp); end
    tick();
    bus_idle();
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL b2b_rd_ready got=%b exp=1", rdy); end
    checks++; if (rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b2b_rdata got=%h exp=deadbeef", rdata); end
    checks++; if (resp !== 1'b0) begin errors++; $display("FAIL b2b_rd_resp got=%b exp=0", resp); end
    tick();
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL rdata_idle got=%h exp=0", rdata); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; int low; logic err;
    sel = 1'b0;
    single(32'h10, 1'b1, 3'd2, 32'h1122_3344, rd, low, err);
    single(32'h13, 1'b1, 3'd0, 32'hA566_7788, rd, low, err);
    single(32'h10, 1'b0, 3'd2, 32'd0, rd, low, err);
    checks++; if (rd !== 32'hA522_3344) begin errors++; $display("FAIL byte_write got=%h exp=a5223344", rd); end
    checks++; if (low !== 0) begin errors++; $display("FAIL ws0_latency got=%0d exp=0", low); end
    single(32'h14, 1'b1, 3'd2, 32'd0, rd, low, err);
    single(32'h16, 1'b1, 3'd1, 32'hCAFE_1234, rd, low, err);
    single(32'h14, 1'b0, 3'd2, 32'd0, rd, low, err);
    checks++; if (rd !== 32'hCAFE_0000) begin errors++; $display("FAIL half_write got=%h exp=cafe0000", rd); end
  endtask

  task automatic test_wait_burst();
    logic [31:0] wd [4];
    logic [31:0] rd; int low; logic err;
    wd[0] = 32'h0101_0101; wd[1] = 32'h2222_2222; wd[2] = 32'h3C3C_3C3C; wd[3] = 32'hF00D_4444;
    sel = 1'b1;
    HBURST = 3'b011;
    addr_phase(32'h40, 1'b1, 3'd2, 2'd2);
    tick();
    for (int i = 0; i < 4; i++) begin
      HWDATA = wd[i];
      if (i < 3) addr_phase(32'h40 + 32'(4*(i+1)), 1'b1, 3'd2, 2'd3);
      else bus_idle();
      low = 0;
      while (!rdy && low < 40) begin
        tick();
        low++;
      end
      checks++; if (low !== 3) begin errors++; $display("FAIL burst_wait beat=%0d got=%0d exp=3", i, low); end
      tick();
    end
    bus_idle();
    for (int i = 0; i < 4; i++) begin
      single(32'h40 + 32'(4*i), 1'b0, 3'd2, 32'd0, rd, low, err);
      checks++; if (rd !== wd[i]) begin errors++; $display("FAIL burst_data beat=%0d got=%h exp=%h", i, rd, wd[i]); end
    end
  endtask

  task automatic test_error();
    logic [31:0] rd; int low; logic err;
    sel = 1'b0;
    addr_phase(32'h1000, 1'b0, 3'd2, 2'd2);
    tick();
    bus_idle();
    checks++; if ({rdy, resp} !== 2'b01) begin errors++; $display("FAIL err1 got rdy,resp=%b%b exp=01", rdy, resp); end
    tick();
    checks++; if ({rdy, resp} !== 2'b11) begin errors++; $display("FAIL err2 got rdy,resp=%b%b exp=11", rdy, resp); end
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL err_rdata got=%h exp=0", rdata); end
    addr_phase(32'h10, 1'b0, 3'd2, 2'd2);
    tick();
    bus_idle();
    checks++; if ({rdy, resp} !== 2'b10) begin errors++; $display("FAIL after_err got rdy,resp=%b%b exp=10", rdy, resp); end
    checks++; if (rdata !== 32'hA522_3344) begin errors++; $display("FAIL after_err_data got=%h exp=a5223344", rdata); end
    tick();
    sel = 1'b1;
    single(32'h1000, 1'b0, 3'd2, 32'd0, rd, low, err);
    checks++; if (low !== 1) begin errors++; $display("FAIL err_ws3_len got=%0d exp=1", low); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_ws3_resp got=%b exp=1", err); end
  endtask

  task automatic test_unaligned();
    logic [31:0] rd; int low; logic err;
    sel = 1'b0;
    single(32'h00, 1'b1, 3'd2, 32'h0BAD_F00D, rd, low, err);
    single(32'h01, 1'b1, 3'd1, 32'hFFFF_FFFF, rd, low, err);
    checks++; if (err !== 1'b1 || low !== 1) begin errors++; $display("FAIL unaligned_half got err=%b low=%0d exp err=1 low=1", err, low); end
    single(32'h10, 1'b1, 3'd3, 32'h0000_0000, rd, low, err);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL oversize got err=%b exp=1", err); end
    single(32'h00, 1'b0, 3'd2, 32'd0, rd, low, err);
    checks++; if (rd !== 32'h0BAD_F00D) begin errors++; $display("FAIL unaligned_mem got=%h exp=0badf00d", rd); end
    single(32'h10, 1'b0, 3'd2, 32'd0, rd, low, err);
    checks++; if (rd !== 32'hA522_3344) begin errors++; $display("FAIL oversize_mem got=%h exp=a5223344", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; int low; logic err;
    sel = 1'b1;
    single(32'h80, 1'b1, 3'd2, 32'h1111_1111, rd, low, err);
    addr_phase(32'h80, 1'b0, 3'd2, 2'd2);
    tick();
    bus_idle();
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL mid_rd_wait got=%b exp=0", rdy); end
    checks++; if (rdata !== 32'h1111_1111) begin errors++; $display("FAIL mid_rd_data got=%h exp=11111111", rdata); end
    tick(); tick(); tick();
    addr_phase(32'h80, 1'b1, 3'd2, 2'd2);
    tick();
    bus_idle();
    HWDATA = 32'h9999_9999;
    tick();
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL mid_wait got=%b exp=0", rdy); end
    #2;
    HRESETn = 1'b0;
    #1;
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got=%b exp=1", rdy); end
    checks++; if (resp !== 1'b0) begin errors++; $display("FAIL mid_rst_resp got=%b exp=0", resp); end
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL mid_rst_rdata got=%h exp=0", rdata); end
    @(negedge HCLK);
    HRESETn = 1'b1;
    tick();
    single(32'h80, 1'b0, 3'd2, 32'd0, rd, low, err);
    checks++; if (rd !== 32'h1111_1111) begin errors++; $display("FAIL mid_rst_nowrite got=%h exp=11111111", rd); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_byte_lanes();
    test_wait_burst();
    test_error();
    test_unaligned();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_lite_mem_slave.md
# ahb_lite_mem_slave

Parametrised AHB-Lite memory slave for the subsystem bus, exposing the full AHB-Lite slave signal set. It generalises the slave side of the bus to configurable data width, depth, base address and wait-state count, and adds a two-cycle ERROR response, byte-lane writes from HSIZE/HADDR, and address-phase/data-phase pipelining. It sits behind the decoder/mux and is driven directly by the bench driver in stand-alone verification.

## Interface
- DATA_WIDTH, 32, HWDATA/HRDATA width; 32 or 64 only.
- ADDR_WIDTH, 32, HADDR width.
- MEM_DEPTH, 1024, memory depth in DATA_WIDTH words; power of two.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to MEM_DEPTH*DATA_WIDTH/8.
- WAIT_STATES, 0, added HREADYOUT-low cycles per OKAY data phase; 0..15.
- HCLK  input  1  bus clock; all state on rising edge.
- HRESETn  input  1  reset, asynchronous, active-low.
- HSEL  input  1  slave select from the decoder.
- HADDR  input  ADDR_WIDTH  byte address.
- HWDATA  input  DATA_WIDTH  write data, valid in the data phase.
- HRDATA  output  DATA_WIDTH  read data.
- HWRITE  input  1  1 = write.
- HSIZE  input  3  transfer size, 2^HSIZE bytes.
- HBURST  input  3  burst type; informational only, no behavioural effect.
- HPROT  input  4  protection; ignored.
- HTRANS  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HREADY  input  1  bus-level ready (mux output).
- HREADYOUT  output  1  slave ready.
- HRESP  output  1  0 = OKAY, 1 = ERROR.

## Operation
- Address-phase capture on rising edge when HSEL & HREADY & HTRANS[1]: register addr, size, write, and valid/error classification. Otherwise no transfer is captured.
- BUSY, IDLE or unselected transfers: zero-wait OKAY, no memory access.
- Error classification is evaluated in the address phase. A transfer is an error when any of these hold:
  - address outside [BASE_ADDR, BASE_ADDR + MEM_DEPTH*DATA_WIDTH/8);
  - HSIZE > log2(DATA_WIDTH/8);
  - HADDR not aligned to 2^HSIZE.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: a captured OKAY transfer goes to WAIT if WAIT_STATES>0, otherwise it completes in one data cycle and stays in IDLE. A captured error transfer goes to ERR1.
  - WAIT: down-counter loaded with WAIT_STATES-1. HREADYOUT=0. At count 0, go to the completion cycle (HREADYOUT=1). On completion, a new capture (HREADY high) re-enters the same decision.
  - ERR1: HREADYOUT=0, HRESP=1, then go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. A transfer sampled on this edge is captured normally. A master switching to IDLE during ERR1/ERR2 is legal and simply not captured.
- Write: byte lanes enabled from size and addr_q low bits. Commits on the edge ending the data phase (HREADYOUT=1, OKAY). Lanes outside the enables are untouched. Error transfers never write.
- Read: HRDATA = full memory word at addr_q, all lanes, during an OKAY read data phase. HRDATA = 0 in every other cycle.
- Write followed by read of the same word: the read returns the new data, because the write commits before the read data phase. No forwarding is required.
- Memory contents are not reset.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0.
- Reset asserted mid-transfer: all outputs return to reset values immediately (asynchronous). A pending write is dropped.
- OKAY latency: data phase lasts 1+WAIT_STATES cycles. Back-to-back transfers are fully pipelined when WAIT_STATES=0.
- ERROR: always exactly 2 data-phase cycles, independent of WAIT_STATES.
- HSEL deasserted while this slave holds HREADYOUT=0: the data phase still completes. Capture follows HREADY, not HSEL alone.

## Structure
- Shared package ahb_lite_pkg: htrans_t, hsize_t, hresp_t enums; slave_state_t (IDLE, WAIT, ERR1, ERR2); byte-lane-mask function (size, addr) -> strobe.
- One sub-module, ahb_lite_mem_array: byte-enable, single-write, asynchronous-read word RAM parametrised by DATA_WIDTH and MEM_DEPTH.

## Test plan
- Reset, then NONSEQ write 32'hDEAD_BEEF to 0x10 followed by a read of 0x10, WAIT_STATES=0 -> both data phases are 1 cycle, HRDATA=32'hDEAD_BEEF, HRESP=0.
- Byte write 8'hA5 to 0x13 over word 0x11223344 -> read returns 32'hA5223344.
- WAIT_STATES=3, INCR4 burst of writes -> each beat has exactly 3 HREADYOUT-low cycles, then 1 high; all 4 words stored.
- Read at BASE_ADDR + 4*MEM_DEPTH (32-bit) -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1); a NONSEQ sampled in ERR2 completes OKAY.
- Halfword write at 0x01 (unaligned), and HSIZE=3 on 32-bit -> ERROR; memory unchanged on readback.
- HRESETn pulled low during a WAIT cycle -> HREADYOUT=1, HRESP=0, HRDATA=0 within the same cycle; the write is not committed.
